// File: rtl/spi_pkg.sv
// Shared types and SPI mode constants for the SPI follower.
// Optional macro SPI_FOLLOWER_SYNC_EN is honoured by spi_edge_detect.
package spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } follower_state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic mode_cpol(input logic [1:0] m);
        return !(m inside {MODE0, MODE1});
    endfunction

    function automatic logic mode_cpha(input logic [1:0] m);
        return !(m inside {MODE0, MODE2});
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Bus input pipeline with sclk edge and CS edge detection.
// SPI_FOLLOWER_SYNC_EN selects a 3-flop (synchronised) pipeline.
module spi_edge_detect
    import spi_pkg::*;
#(
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sample_ev,
    output logic shift_ev,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_lvl,
    output logic mosi_d
);

`ifdef SPI_FOLLOWER_SYNC_EN
    localparam int E = 3;
`else
    localparam int E = 1;
`endif

    localparam logic [1:0] MODE = {CPOL != 0, CPHA != 0};
    localparam logic POL = mode_cpol(MODE);
    localparam logic PHA = mode_cpha(MODE);

    // One extra stage past the pipeline holds the previous value.
    logic [E:0]   sclk_p;
    logic [E:0]   cs_p;
    logic [E-1:0] mosi_p;
    logic         lead_ev;
    logic         trail_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p <= {(E+1){POL}};
            cs_p   <= '1;
            mosi_p <= '0;
        end else begin
            sclk_p[0] <= sclk;
            cs_p[0]   <= cs;
            mosi_p[0] <= mosi;
            for (int i = 1; i <= E; i++) begin
                sclk_p[i] <= sclk_p[i-1];
                cs_p[i]   <= cs_p[i-1];
            end
            for (int i = 1; i < E; i++) begin
                mosi_p[i] <= mosi_p[i-1];
            end
        end
    end

    assign lead_ev   = (sclk_p[E] == POL) && (sclk_p[E-1] != POL);
    assign trail_ev  = (sclk_p[E] != POL) && (sclk_p[E-1] == POL);
    assign sample_ev = PHA ? trail_ev : lead_ev;
    assign shift_ev  = PHA ? lead_ev : trail_ev;
    assign cs_fall   = cs_p[E] && !cs_p[E-1];
    assign cs_rise   = !cs_p[E] && cs_p[E-1];
    assign cs_lvl    = cs_p[E-1];
    assign mosi_d    = mosi_p[E-1];

endmodule

// File: rtl/spi_follower.sv
// SPI follower endpoint, oversampled on clk, one-deep tx buffer.
// Define SPI_FOLLOWER_SYNC_EN for an asynchronous leader clock.
module spi_follower
    import spi_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                CS,
    input  logic                mosi,
    output logic                miso,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                tx_underrun
);

    localparam int CW = $clog2(DATA_LEN);
    localparam logic [1:0] MODE = {CPOL != 0, CPHA != 0};
    localparam logic FIRST_SKIP = mode_cpha(MODE);

    logic                sample_ev;
    logic                shift_ev;
    logic                cs_fall;
    logic                cs_rise;
    logic                cs_lvl;
    logic                mosi_d;

    follower_state_t     state;
    logic [CW-1:0]       cnt;
    logic [DATA_LEN-1:0] tx_sr;
    logic [DATA_LEN-2:0] rx_sr;
    logic [DATA_LEN-1:0] rx_next;
    logic [DATA_LEN-1:0] buf_data;
    logic [DATA_LEN-1:0] load_word;
    logic                buf_full;
    logic                pend;
    logic                skip;
    logic                ws;
    logic                last;

    spi_edge_detect #(
        .CPOL(CPOL),
        .CPHA(CPHA)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (CS),
        .mosi     (mosi),
        .sample_ev(sample_ev),
        .shift_ev (shift_ev),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_lvl   (cs_lvl),
        .mosi_d   (mosi_d)
    );

    // Word start: CS fall from idle, or a back-to-back word boundary.
    always_comb begin
        ws = 1'b0;
        unique case (state)
            IDLE:    ws = cs_fall;
            ACTIVE:  ws = pend && shift_ev && !cs_lvl;
            default: ws = 1'b0;
        endcase
    end

    assign last      = cnt == CW'(DATA_LEN - 1);
    assign rx_next   = {rx_sr, mosi_d};
    assign load_word = buf_full ? buf_data : '0;
    assign tx_ready  = !buf_full;
    assign miso      = tx_sr[DATA_LEN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (tx_valid && !buf_full) begin
            buf_data <= tx_data;
            buf_full <= 1'b1;
        end else if (ws) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            pend        <= 1'b0;
            skip        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= ws && !buf_full;
            unique case (state)
                IDLE: begin
                    cnt   <= '0;
                    pend  <= 1'b0;
                    tx_sr <= '0;
                    if (cs_fall) begin
                        state <= ACTIVE;
                        skip  <= FIRST_SKIP;
                    end
                end
                ACTIVE: begin
                    if (sample_ev) begin
                        rx_sr <= rx_next[DATA_LEN-2:0];
                        if (last) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            pend     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    // MSB is already on miso at word start.
                    if (shift_ev && !ws) begin
                        if (skip) begin
                            skip <= 1'b0;
                        end else begin
                            tx_sr <= {tx_sr[DATA_LEN-2:0], 1'b0};
                        end
                    end
                    if (cs_rise) begin
                        state <= IDLE;
                        tx_sr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ws) begin
                tx_sr <= load_word;
                pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_follower.sv
// Scoreboard bench for spi_follower in all four SPI modes.
// One DUT per mode; a bench-side leader drives the bus.
module tb_spi_follower;
    import spi_pkg::*;

    localparam int HALF = 4;

    logic       clk;
    logic       rst;
    logic       sclk_v     [4];
    logic       cs_v       [4];
    logic       mosi_v     [4];
    logic       miso_v     [4];
    logic [7:0] tx_data_v  [4];
    logic       tx_valid_v [4];
    logic       tx_ready_v [4];
    logic [7:0] rx_data_v  [4];
    logic       rx_valid_v [4];
    logic       und_v      [4];

    int         n_cmp;
    int         n_bad;
    int         rx_cnt [4];
    int         und_cnt [4];
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_follower #(
            .DATA_LEN(8),
            .CPOL    (g / 2),
            .CPHA    (g % 2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sclk       (sclk_v[g]),
            .CS         (cs_v[g]),
            .mosi       (mosi_v[g]),
            .miso       (miso_v[g]),
            .tx_data    (tx_data_v[g]),
            .tx_valid   (tx_valid_v[g]),
            .tx_ready   (tx_ready_v[g]),
            .rx_data    (rx_data_v[g]),
            .rx_valid   (rx_valid_v[g]),
            .tx_underrun(und_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_cnt[i]  = 0;
            und_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid_v[i] === 1'b1) begin
                obs_q.push_back(rx_data_v[i]);
                rx_cnt[i] = rx_cnt[i] + 1;
            end
            if (und_v[i] === 1'b1) begin
                und_cnt[i] = und_cnt[i] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_buf(input int m, input logic [7:0] d);
        int k;
        k = 0;
        while (tx_ready_v[m] !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (tx_ready_v[m] !== 1'b1) begin
            n_bad++;
            $display("FAIL load_buf m%0d: tx_ready=%b want 1",
                     m, tx_ready_v[m]);
        end
        tx_data_v[m]  = d;
        tx_valid_v[m] = 1'b1;
        tick(1);
        tx_valid_v[m] = 1'b0;
    endtask

    // Leader side: shifts w out MSB first, collects miso into got.
    task automatic xfer(input int m, input logic [15:0] w,
                        input int nb, input bit rel,
                        output logic [15:0] got);
        logic pol;
        logic pha;
        pol = m[1];
        pha = m[0];
        got = '0;
        cs_v[m] = 1'b0;
        if (!pha) mosi_v[m] = w[nb-1];
        tick(HALF);
        for (int i = 0; i < nb; i++) begin
            sclk_v[m] = !pol;
            if (pha) mosi_v[m] = w[nb-1-i];
            else got = {got[14:0], miso_v[m]};
            tick(HALF);
            if (pha) got = {got[14:0], miso_v[m]};
            else if (i < nb - 1) mosi_v[m] = w[nb-2-i];
            sclk_v[m] = pol;
            if (rel && i == nb - 1) cs_v[m] = 1'b1;
            tick(HALF);
        end
        if (rel) mosi_v[m] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if (miso_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_miso: got %b want 0", miso_v[0]);
        end
        n_cmp++;
        if (rx_data_v[0] !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_rx_data: got %h want 00", rx_data_v[0]);
        end
        n_cmp++;
        if ({rx_valid_v[0], und_v[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_pulses: got %b%b want 00",
                     rx_valid_v[0], und_v[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tx_ready_v[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_tx_ready m%0d: got %b want 1",
                         i, tx_ready_v[i]);
            end
        end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_mode0;
        logic [15:0] got;
        logic [7:0]  e;
        logic [7:0]  o;
        int          r0;
        load_buf(0, 8'h3C);
        n_cmp++;
        if (tx_ready_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_ready_low: got %b want 0", tx_ready_v[0]);
        end
        r0 = rx_cnt[0];
        exp_q.push_back(8'hA5);
        xfer(0, 16'h00A5, 8, 1'b1, got);
        tick(4);
        e = exp_q.pop_front();
        o = 8'hxx;
        if (obs_q.size() != 0) o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL m0_rx: got %h want %h", o, e);
        end
        n_cmp++;
        if (got[7:0] !== 8'h3C) begin
            n_bad++;
            $display("FAIL m0_miso_word: got %h want 3c", got[7:0]);
        end
        n_cmp++;
        if (rx_cnt[0] - r0 !== 1) begin
            n_bad++;
            $display("FAIL m0_rx_pulses: got %0d want 1", rx_cnt[0] - r0);
        end
        n_cmp++;
        if ({tx_ready_v[0], miso_v[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL m0_after: ready,miso=%b%b want 10",
                     tx_ready_v[0], miso_v[0]);
        end
    endtask

    task automatic test_modes123;
        logic [15:0] got;
        logic [7:0]  e;
        logic [7:0]  o;
        int          r0;
        for (int m = 1; m < 4; m++) begin
            load_buf(m, 8'hC3);
            r0 = rx_cnt[m];
            exp_q.push_back(8'h5A);
            xfer(m, 16'h005A, 8, 1'b1, got);
            tick(4);
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL m%0d_rx: got %h want %h", m, o, e);
            end
            n_cmp++;
            if (got[7:0] !== 8'hC3) begin
                n_bad++;
                $display("FAIL m%0d_miso_word: got %h want c3",
                         m, got[7:0]);
            end
            n_cmp++;
            if (rx_cnt[m] - r0 !== 1) begin
                n_bad++;
                $display("FAIL m%0d_rx_pulses: got %0d want 1",
                         m, rx_cnt[m] - r0);
            end
        end
    endtask

    task automatic test_underrun;
        logic [15:0] got;
        logic [7:0]  e;
        logic [7:0]  o;
        int          u0;
        u0 = und_cnt[0];
        exp_q.push_back(8'hFF);
        xfer(0, 16'h00FF, 8, 1'b1, got);
        tick(4);
        e = exp_q.pop_front();
        o = 8'hxx;
        if (obs_q.size() != 0) o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL und_rx: got %h want %h", o, e);
        end
        n_cmp++;
        if (got[7:0] !== 8'h00) begin
            n_bad++;
            $display("FAIL und_miso_word: got %h want 00", got[7:0]);
        end
        n_cmp++;
        if (und_cnt[0] - u0 !== 1) begin
            n_bad++;
            $display("FAIL und_pulses: got %0d want 1", und_cnt[0] - u0);
        end
    endtask

    task automatic test_abort;
        logic [15:0] got;
        int          r0;
        r0 = rx_cnt[0];
        xfer(0, 16'h0005, 3, 1'b1, got);
        tick(6);
        n_cmp++;
        if (rx_cnt[0] - r0 !== 0) begin
            n_bad++;
            $display("FAIL abort_rx_pulses: got %0d want 0",
                     rx_cnt[0] - r0);
        end
        n_cmp++;
        if (rx_data_v[0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL abort_rx_data: got %h want ff", rx_data_v[0]);
        end
        n_cmp++;
        if (g_dut[0].u_dut.state !== IDLE) begin
            n_bad++;
            $display("FAIL abort_state: got %0d want IDLE",
                     g_dut[0].u_dut.state);
        end
        n_cmp++;
        if (miso_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_miso: got %b want 0", miso_v[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        logic [7:0]  e;
        logic [7:0]  o;
        int          r0;
        int          u0;
        load_buf(0, 8'h11);
        r0 = rx_cnt[0];
        u0 = und_cnt[0];
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        fork
            xfer(0, 16'hA1B2, 16, 1'b1, got);
            begin
                tick(HALF + 4);
                load_buf(0, 8'h22);
            end
        join
        tick(4);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_rx%0d: got %h want %h", k, o, e);
            end
        end
        n_cmp++;
        if (got !== 16'h1122) begin
            n_bad++;
            $display("FAIL b2b_miso_words: got %h want 1122", got);
        end
        n_cmp++;
        if (rx_cnt[0] - r0 !== 2) begin
            n_bad++;
            $display("FAIL b2b_rx_pulses: got %0d want 2", rx_cnt[0] - r0);
        end
        n_cmp++;
        if (und_cnt[0] - u0 !== 0) begin
            n_bad++;
            $display("FAIL b2b_underrun: got %0d want 0", und_cnt[0] - u0);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [15:0] got;
        logic [7:0]  e;
        logic [7:0]  o;
        load_buf(0, 8'hFF);
        xfer(0, 16'h0009, 4, 1'b0, got);
        load_buf(0, 8'hEE);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (miso_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_miso: got %b want 0", miso_v[0]);
        end
        n_cmp++;
        if (tx_ready_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: got %b want 1", tx_ready_v[0]);
        end
        n_cmp++;
        if (rx_data_v[0] !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_rx_data: got %h want 00", rx_data_v[0]);
        end
        cs_v[0]   = 1'b1;
        sclk_v[0] = 1'b0;
        mosi_v[0] = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);
        load_buf(0, 8'h69);
        exp_q.push_back(8'h96);
        xfer(0, 16'h0096, 8, 1'b1, got);
        tick(4);
        e = exp_q.pop_front();
        o = 8'hxx;
        if (obs_q.size() != 0) o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL midrst_rx: got %h want %h", o, e);
        end
        n_cmp++;
        if (got[7:0] !== 8'h69) begin
            n_bad++;
            $display("FAIL midrst_miso_word: got %h want 69", got[7:0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sclk_v[i]     = (i >= 2);
            cs_v[i]       = 1'b1;
            mosi_v[i]     = 1'b0;
            tx_data_v[i]  = 8'h00;
            tx_valid_v[i] = 1'b0;
        end
        test_reset();
        test_mode0();
        test_modes123();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_word();
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL extra_rx: got %0d words want 0", obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_follower.md
Name: spi_follower

Overview:
- SPI follower (peripheral) endpoint on the far side of the SPI bus from the leader.
- Consumes the leader's sclk, mosi and CS, and drives miso back.
- All bus inputs are oversampled by the local clk; no logic runs on sclk.
- Presents received words on a parallel valid pulse; accepts the next transmit word through a one-deep valid/ready buffer.

Parameters:
- DATA_LEN, 8: word length in bits, MSB first; must be at least 2.
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- clk  in  1  system clock; sclk frequency must be at most clk/4.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from leader.
- CS  in  1  chip select, active low.
- mosi  in  1  serial data from leader.
- miso  out  1  serial data to leader.
- tx_data  in  DATA_LEN  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmit buffer empty.
- rx_data  out  DATA_LEN  last complete received word.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- tx_underrun  out  1  one-cycle pulse, a word started with an empty transmit buffer.

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, state IDLE, bit counter 0, transmit buffer empty.
- Input path: sclk, CS and mosi each pass through a pipeline of E flops, with the same delay for all three. E=1 without SPI_FOLLOWER_SYNC_EN, E=3 with it.
- Edge events are derived from the last two pipeline stages.
  - Leading edge: sclk leaves the CPOL level.
  - Trailing edge: sclk returns to the CPOL level.
  - sample_ev and shift_ev are selected from these per CPHA.
- Transmit buffer: accepts tx_data when tx_valid && tx_ready; tx_ready then falls on the next cycle. The buffer is emptied at each word start and tx_ready rises the next cycle. Accept and consume in the same cycle: the new word is buffered for the following word.
- FSM state IDLE: miso=0, counter=0.
  - On a delayed CS falling edge, go to ACTIVE and perform a word start.
- Word start:
  - The tx shift register loads the buffer, or all zeros if the buffer is empty; an empty buffer also pulses tx_underrun.
  - miso = shift register MSB from the next cycle.
- FSM state ACTIVE:
  - On shift_ev, the tx shift register shifts left and miso takes the new MSB.
    - Exception for CPHA=1: the first leading edge of each word does not shift, because the MSB was already presented at word start.
  - On sample_ev, the delayed mosi is shifted into the LSB of the rx shift register and the counter increments.
  - When the counter reaches DATA_LEN:
    - rx_data takes the full register and rx_valid pulses on the next clk.
    - The counter returns to 0.
    - A word start is performed at the next shift_ev with CS still low (back-to-back words).
- CS rising (delayed), in any state: go to IDLE the next cycle.
  - A partial word is discarded with no rx_valid.
  - miso=0.
  - The transmit buffer is left unchanged.
- rx_valid has no backpressure; rx_data holds until the next complete word.
- Simultaneous CS rise and final sample_ev: the word completes (rx_valid pulses), then the block goes to IDLE.
- Reset mid-word: all outputs return to reset values immediately; the bus transfer is lost.

Optional Feature:
- SPI_FOLLOWER_SYNC_EN
- Defined: two-flop metastability synchronisers on sclk, CS and mosi (E=3). Required when the leader clock domain is asynchronous to clk. Adds 2 clk of latency to all bus events.
- Undefined: single registration only (E=1), for a leader sharing clk. Functional behaviour is otherwise identical.

Decomposition:
- Shared package spi_pkg:
  - typedef follower_state_t {IDLE, ACTIVE}.
  - SPI mode constants (MODE0..MODE3 as {CPOL,CPHA}).
- Sub-module spi_edge_detect: input pipeline plus leading/trailing edge and CS fall/rise detection. Parameterised by CPOL and CPHA; honours SPI_FOLLOWER_SYNC_EN.

Test Plan:
- Mode 0: tx buffer 8'h3C, leader sends 8'hA5 with sclk = clk/8 -> rx_data=8'hA5 with one rx_valid pulse; leader receives 8'h3C; tx_ready rises after CS fall.
- Modes 1, 2 and 3 (parameter overrides): leader sends 8'h5A and the buffer holds 8'hC3 -> both sides exchange correctly in every mode; no extra shift at the CPHA=1 first edge.
- Empty buffer: leader sends 8'hFF -> tx_underrun pulses once, miso stays 0 for 8 bits, rx_data=8'hFF.
- Abort: CS rises after 3 bits -> no rx_valid, rx_data unchanged, FSM returns to IDLE, miso=0.
- Back-to-back: CS held low for 16 bits, buffer refilled with 8'h11 then 8'h22 -> two rx_valid pulses; leader receives 8'h11 then 8'h22.
- Reset asserted mid-word at bit 4 -> outputs at reset values in the same cycle; the next full transfer of 8'h96 is received correctly.
